muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multicycle signed multiply/divide unit with its own sequencing FSM and architectural HI/LO registers. It serves MULT and DIV in the multicycle CPU. The main control unit pulses `start` with operands taken from Reg A and Reg B, waits on `busy`/`done`, and reads `hi`/`lo` through the MemtoReg mux for MFHI/MFLO. `div_zero` is the divide-by-zero exception source for the control unit.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits. Only 32 is verified.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE; ignored in every other state.
- `op`  in  1  0 = MULT, 1 = DIV. Both are signed. Sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (Reg A). Sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor (Reg B). Sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, high only in DONE.
- `div_zero`  out  1  high in DONE only when the completed op was DIV with b = 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX, DONE. A 6-bit iteration counter is used in RUN.
- IDLE, start=1, op=MULT:
  - Latch sign flags and magnitudes |a|, |b| as unsigned. |0x80000000| = 0x80000000.
  - Clear the 64-bit accumulator and counter, then go to RUN.
- IDLE, start=1, op=DIV, b≠0:
  - Latch sign flags, |a| as shifting dividend, |b| as divisor.
  - Clear the partial remainder, then go to RUN.
- IDLE, start=1, op=DIV, b=0:
  - Go straight to DONE with the div_zero flag set.
  - HI/LO are not written.
- RUN, MULT: one shift-add step per cycle, LSB-first on |b|. This yields a 64-bit unsigned product after 32 steps.
- RUN, DIV: one restoring step per cycle. Shift the remainder left with the next dividend bit, then trial-subtract |b|. If the result is ≥ 0, keep it and shift in quotient bit 1; otherwise shift in 0.
- RUN exits to FIX when the counter reaches 31 at an edge, i.e. after exactly 32 steps.
- FIX, MULT: negate the 64-bit product (two's complement) if sign(a) ≠ sign(b). Write {hi, lo} = product, then go to DONE.
- FIX, DIV: lo = quotient, negated if sign(a) ≠ sign(b). hi = remainder, negated if a < 0. Go to DONE.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (natural wrap, no flag).
- DONE: assert `done` (and `div_zero` if flagged). Go to IDLE unconditionally. The div_zero flag clears on leaving DONE.
- HI/LO are written only at the FIX→DONE edge and hold their value otherwise, including across div-by-zero.
- No abort input. Only reset cancels an operation.

## Timing
- Reset (asynchronous, while `rst`=0):
  - State is IDLE; counter, accumulators and flags are 0.
  - Outputs: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0.
- Reset mid-operation discards all progress; no `done` is produced.
- Let E0 be the edge that samples `start`=1 in IDLE. Normal op:
  - E1..E32: RUN steps.
  - E33: FIX→DONE, HI/LO written.
  - Cycle E33–E34: `done`=1.
  - E34: back to IDLE.
  - Latency is 33 cycles. The earliest next accepted `start` is at E35.
- Divide by zero: E0→DONE. `done`=`div_zero`=1 in cycle E0–E1. E1→IDLE.
- `busy` rises the cycle after E0 and falls after the DONE cycle. It is never high in IDLE.
- `start` held high is accepted once per IDLE visit. `start` during busy has no effect; operand changes during busy have no effect.
- `hi`/`lo` are stable throughout RUN/FIX. The control unit may read old values during busy.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3):
  - Expect hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - `done` high exactly in cycle E33–E34; `busy` high E0+1..E34.
- MULT a=b=0x80000000:
  - Expect hi=0x40000000, lo=0x00000000.
  - Then MULT 0xFFFFFFFF×0xFFFFFFFF gives hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2:
  - Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 7/−2 gives lo=0xFFFFFFFD, hi=1.
  - DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIV a=5, b=0 with hi/lo preloaded by a prior MULT:
  - `done`=`div_zero`=1 for one cycle immediately after E0.
  - hi/lo unchanged; back in IDLE at E1.
- `start` pulsed with new operands at E5 and E20 of a MULT: ignored, and the result matches the original operands.
  - A `start` held high through DONE is re-accepted only at E35.
- `rst`=0 asynchronously mid-RUN at step 10:
  - hi=lo=0, busy=0 immediately; no `done` pulse.
  - After release, MULT 3×4 yields hi=0, lo=12 at E33.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle signed MULT/DIV unit with HI/LO registers.
// Ports: clk; rst (async, active-low); start/op/a/b request;
//        busy/done/div_zero status; hi/lo architectural results.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int         W2   = 2 * WIDTH;
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [5:0]       cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] mcand;
  logic [W2-1:0]    acc;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             b_zero;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nx;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic [W2-1:0]    div_nx;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Magnitudes; the most negative value maps onto itself,
  // which reads correctly as an unsigned magnitude.
  assign mag_a  = a[WIDTH-1] ? -a : a;
  assign mag_b  = b[WIDTH-1] ? -b : b;
  assign b_zero = (b == '0);

  // MULT: upper half accumulates, lower half holds the
  // not-yet-consumed multiplier bits (LSB first).
  assign mul_sum = {1'b0, acc[W2-1:WIDTH]}
                 + {1'b0, {WIDTH{acc[0]}} & mcand};
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // DIV: upper half is the partial remainder, lower half
  // shifts dividend bits out and quotient bits in.
  // rem < divisor <= 2^(WIDTH-1), so the shifted remainder
  // always fits in WIDTH bits.
  assign rem_sh = acc[W2-2:WIDTH-1];
  assign trial  = {1'b0, rem_sh} - {1'b0, mcand};
  assign div_nx = trial[WIDTH]
                ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    div_zero = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (op && b_zero) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        div_zero = dz;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op;
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            cnt    <= '0;
            if (op && b_zero) begin
              dz <= 1'b1;
            end else begin
              mcand <= op ? mag_b : mag_a;
              acc   <= {{WIDTH{1'b0}}, op ? mag_a : mag_b};
            end
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          acc <= is_div ? div_nx : mul_nx;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[W2-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        DONE: begin
          dz <= 1'b0;
        end
        default: begin
          dz <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench for muldiv_sequencer.
// Per-cycle compare against an arithmetic timeline model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total = 0;
  logic chk_on = 1'b0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] got,
                              logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endfunction

  function automatic logic [63:0] mul_model(logic [31:0] x,
                                            logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  function automatic logic [63:0] div_model(logic [31:0] x,
                                            logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Timeline model: m_t = -1 idle, else cycles since accept;
  // 33 is the done cycle (entered directly on divide by zero).
  int          m_t = -1;
  logic        m_dz = 1'b0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t  <= -1;
      m_dz <= 1'b0;
      m_hi <= '0;
      m_lo <= '0;
    end else if (m_t < 0) begin
      if (start) begin
        if (op && b == 32'd0) begin
          m_t  <= 33;
          m_dz <= 1'b1;
        end else begin
          m_t    <= 0;
          m_pend <= op ? div_model(a, b) : mul_model(a, b);
        end
      end
    end else if (m_t >= 33) begin
      m_t  <= -1;
      m_dz <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t == 32) {m_hi, m_lo} <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_ctl", {61'd0, busy, done, div_zero},
          {61'd0, m_t >= 0, m_t == 33, m_t == 33 && m_dz});
      chk("cyc_hilo", {hi, lo}, {m_hi, m_lo});
    end
  end

  task automatic do_op(input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int ek,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input string nm);
    int k;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    chk({nm, "_busy0"}, busy, 1);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, k, ek);
    chk({nm, "_dz"}, div_zero, edz);
    chk({nm, "_res"}, {hi, lo}, {eh, el});
    @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int d1;
    int d2;
    logic b34;
    logic b35;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctl", {busy, done, div_zero}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op(0, 32'd7, 32'hFFFFFFFD, 33,
          32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mul_7xm3");
    do_op(1, 32'd5, 32'd0, 0,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1, "div_5by0");
    do_op(0, 32'h80000000, 32'h80000000, 33,
          32'h40000000, 32'h00000000, 0, "mul_minxmin");
    do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
          32'h0, 32'h1, 0, "mul_m1xm1");
    do_op(1, 32'hFFFFFFF9, 32'd2, 33,
          32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_m7by2");
    do_op(1, 32'd7, 32'hFFFFFFFE, 33,
          32'h1, 32'hFFFFFFFD, 0, "div_7bym2");
    do_op(1, 32'h80000000, 32'hFFFFFFFF, 33,
          32'h0, 32'h80000000, 0, "div_minbym1");
    do_op(1, 32'd100, 32'd7, 33,
          32'd2, 32'd14, 0, "div_100by7");

    // start pulses at E5 and E20 with other operands
    start = 1'b1;
    op = 1'b0;
    a = 32'd100;
    b = 32'hFFFFFFFB;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 4 || k == 19) begin
        start = 1'b1;
        op = 1'b1;
        a = $urandom;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("ign_lat", k, 33);
    chk("ign_res", {hi, lo}, 64'hFFFFFFFF_FFFFFE0C);
    @(negedge clk);

    // start held high through DONE
    start = 1'b1;
    op = 1'b0;
    a = 32'd6;
    b = 32'd7;
    d1 = -1;
    d2 = -1;
    b34 = 1'b1;
    b35 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done && d1 < 0) d1 = i;
      else if (done && d2 < 0) d2 = i;
      if (i == 34) b34 = busy;
      if (i == 35) begin
        b35 = busy;
        start = 1'b0;
      end
    end
    chk("held_d1", d1, 33);
    chk("held_b34", b34, 0);
    chk("held_b35", b35, 1);
    chk("held_d2", d2, 68);
    chk("held_res", {hi, lo}, 64'd42);

    // asynchronous reset after 10 RUN steps
    start = 1'b1;
    op = 1'b0;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_ctl", {busy, done, div_zero}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(0, 32'd3, 32'd4, 33, 32'd0, 32'd12, 0, "mul_3x4");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
